// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte out on device clock falls and collects the device ack bit.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int REQ_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int CNT_W  = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_REQ     = 3'd2,
    S_SHIFT   = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  logic clk_s1_q, clk_sync_q, clk_prev_q, fall_q;
  logic dat_s1_q, dat_sync_q;

  state_t           state_q, state_d;
  logic [9:0]       shreg_q, shreg_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             ack_bit_q, ack_bit_d;
  logic             done_q, done_d;
  logic             ack_ok_q, ack_ok_d;
  logic             error_q, error_d;
  logic             ready_q, ready_d;

  // Line synchronisers (idle-high) and registered falling-edge detect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      dat_s1_q   <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_sync_q <= clk_s1_q;
      clk_prev_q <= clk_sync_q;
      fall_q     <= clk_prev_q & ~clk_sync_q;
      dat_s1_q   <= ps2_dat_i;
      dat_sync_q <= dat_s1_q;
    end
  end

  // Next-state and next-output logic for the transmit sequencer
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    cnt_d     = cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    ack_bit_d = ack_bit_q;
    done_d    = 1'b0;
    ack_ok_d  = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          shreg_d  = {1'b1, odd_parity(tx_data), tx_data};
          bitcnt_d = 4'd0;
          cnt_d    = {CNT_W{1'b0}};
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d    = {CNT_W{1'b0}};
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REQ: begin
        if (cnt_q == REQ_LAST) begin
          cnt_d    = {CNT_W{1'b0}};
          clk_oe_d = 1'b0;
          to_cnt_d = {TO_W{1'b0}};
          state_d  = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        // Ten falls carry data LSB first, then parity, then stop
        if (fall_q) begin
          dat_oe_d = ~shreg_q[0];
          shreg_d  = {1'b0, shreg_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) begin
            state_d = S_ACK;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ACK: begin
        if (fall_q) begin
          ack_bit_d = ~dat_sync_q;
          state_d   = S_RELEASE;
        end else begin
          state_d = S_ACK;
        end
      end
      S_RELEASE: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d   = 1'b1;
          ack_ok_d = ack_bit_q;
          state_d  = S_IDLE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    // The device-driven phase is bounded; expiry wins over a same-cycle done
    if (state_q == S_SHIFT || state_q == S_ACK || state_q == S_RELEASE) begin
      if (to_cnt_q == TO_LAST) begin
        state_d  = S_IDLE;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        error_d  = 1'b1;
        done_d   = 1'b0;
        ack_ok_d = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = to_cnt_d;
    end

    ready_d = (state_d == S_IDLE);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= 10'd0;
      bitcnt_q  <= 4'd0;
      cnt_q     <= {CNT_W{1'b0}};
      to_cnt_q  <= {TO_W{1'b0}};
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ack_bit_q <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      error_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      cnt_q     <= cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ack_bit_q <= ack_bit_d;
      done_q    <= done_d;
      ack_ok_q  <= ack_ok_d;
      error_q   <= error_d;
      ready_q   <= ready_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_ready   = ready_q;
  assign busy       = ~ready_q;
  assign done       = done_q;
  assign ack_ok     = ack_ok_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device drives the shared
// open-collector lines and every observation is checked against hand values.
module tb_ps2_host_tx;

  localparam int INH  = 300;
  localparam int REQ  = 20;
  localparam int TO   = 5000;
  localparam int HALF = 50;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_i, ps2_dat_i;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, busy, done, ack_ok, error;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic last_ack = 1'b0;

  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .ack_ok    (ack_ok),
    .error     (error)
  );

  always #5 clock = ~clock;

  // Pulse counters: each high cycle of done/error is counted once
  always @(posedge clock) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      last_ack = ack_ok;
    end
    if (error) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  // Device side: waits for clock release, generates 11 falls, records dat_oe
  // late in each low phase, optionally acks, aborts via reset or injects a
  // stray tx_valid pulse at the given edge numbers (0 = never)
  task automatic device(input logic ack, input int late, input int abort_edge,
                        input int pulse_edge, output logic [9:0] oe_bits,
                        output logic aborted);
    int n;
    oe_bits = 10'd0;
    aborted = 1'b0;
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < INH + REQ + 100) begin
      @(negedge clock);
      n++;
    end
    check("release_seen", (n < INH + REQ + 100), 1'b1);
    repeat (20) @(negedge clock);
    for (int e = 1; e <= 11; e++) begin
      if (e == 11 && ack) dev_dat = 1'b0;
      dev_clk = 1'b0;
      if (e == abort_edge) begin
        #2;
        check("abort_pre_dat_oe", ps2_dat_oe, 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort_clk_oe", ps2_clk_oe, 1'b0);
        check("abort_dat_oe", ps2_dat_oe, 1'b0);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (e == pulse_edge) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        repeat (HALF - 1) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
      if (e <= 10) oe_bits[e-1] = ps2_dat_oe;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clock);
    end
    if (!aborted && ack) begin
      repeat (late) @(negedge clock);
      dev_dat = 1'b1;
    end
  endtask

  task automatic finish_frame(input string tag, input logic [9:0] bits,
                              input logic [9:0] exp_bits, input logic exp_ack,
                              input int d0, input int e0);
    repeat (10) @(negedge clock);
    check({tag, "_oe_bits"}, bits, exp_bits);
    check({tag, "_done_count"}, done_cnt, d0 + 1);
    check({tag, "_ack_ok"}, last_ack, exp_ack);
    check({tag, "_no_error"}, err_cnt, e0);
    check({tag, "_ready"}, tx_ready, 1'b1);
  endtask

  initial begin
    logic [9:0] bits;
    logic       ab;
    int d0, e0, n, m, k;

    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_dat_oe", ps2_dat_oe, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_ack_ok", ack_ok, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_ready", tx_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // 0xF4 with ack: frame 1_0_11110100, pull-low pattern is its complement
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    check("f4_busy", busy, 1'b1);
    device(1'b1, 20, 0, 0, bits, ab);
    check("f4_no_early_done", done_cnt, d0);
    finish_frame("f4", bits, 10'h10B, 1'b1, d0, e0);

    // 0xED nack: six ones -> parity 1, frame 1_1_11101101
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    device(1'b0, 0, 0, 0, bits, ab);
    check("ed_parity_edge9", bits[8], 1'b0);
    finish_frame("ed", bits, 10'h012, 1'b0, d0, e0);

    // 0x00, silent device: inhibit, request, then timeout
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < 2 * INH) begin
      n++;
      @(negedge clock);
    end
    check("to_inhibit_cycles", n, INH);
    m = 0;
    while (ps2_clk_oe && ps2_dat_oe && m < 2 * REQ) begin
      m++;
      @(negedge clock);
    end
    check("to_req_cycles", m, REQ);
    k = 0;
    while (!error && k < TO + 100) begin
      k++;
      @(negedge clock);
    end
    check("to_timeout_cycles", k, TO);
    check("to_clk_oe", ps2_clk_oe, 1'b0);
    check("to_dat_oe", ps2_dat_oe, 1'b0);
    check("to_ready", tx_ready, 1'b1);
    check("to_ack_ok", ack_ok, 1'b0);
    @(negedge clock);
    check("to_error_one_cycle", error, 1'b0);
    repeat (5) @(negedge clock);
    check("to_no_done", done_cnt, d0);
    check("to_error_count", err_cnt, e0 + 1);

    // 0xFF with a stray 0x55 request at edge 3
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF);
    device(1'b1, 20, 0, 3, bits, ab);
    finish_frame("ff", bits, 10'h000, 1'b1, d0, e0);
    repeat (50) @(negedge clock);
    check("ff_no_queued_clk_oe", ps2_clk_oe, 1'b0);
    check("ff_no_queued_done", done_cnt, d0 + 1);

    // 0xF4 abandoned by reset at edge 5, then a clean 0xF4
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    device(1'b1, 20, 5, 0, bits, ab);
    check("abort_taken", ab, 1'b1);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("abort_ready", tx_ready, 1'b1);
    repeat (20) @(negedge clock);
    check("abort_no_done", done_cnt, d0);
    check("abort_no_error", err_cnt, e0);
    send(8'hF4);
    device(1'b1, 20, 0, 0, bits, ab);
    finish_frame("f4_retry", bits, 10'h10B, 1'b1, d0, e0);

    // Device holds data low 2000 cycles after edge 11
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    device(1'b1, 2000, 0, 0, bits, ab);
    check("late_no_early_done", done_cnt, d0);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("late_done_seen", done, 1'b1);
    check("late_done_within_3", (n <= 3), 1'b1);
    finish_frame("late", bits, 10'h10B, 1'b1, d0, e0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
